// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider bank: default counter width and
// the rule that turns a programmed divide value into the half-period actually used.
package clkdiv_pkg;

  localparam int CW_DEFAULT = 32;

  // A programmed 0 would never reach a terminal count, so it runs as 1 (clk/2).
  function automatic logic [63:0] clamp_div(input logic [63:0] div);
    return (div == 64'd0) ? 64'd1 : div;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, 50% duty output and a rising-edge tick.
// Sync outranks a load, and a load outranks the terminal count.
module clk_div_channel
  import clkdiv_pkg::*;
#(
  parameter int               CW   = CW_DEFAULT,
  parameter logic [CW-1:0]    INIT = CW'(1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0] div;
  logic [CW-1:0] cnt;
  logic [CW-1:0] eff;
  logic          terminal;

  assign eff      = CW'(clamp_div(64'(div)));
  assign terminal = (cnt == eff - CW'(1));

  // Tick defaults low every cycle so it can only ever be a single-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= INIT;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load) begin
        div <= load_val;
      end
      if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (load) begin
        cnt <= '0;
      end else if (en) begin
        if (terminal) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel runtime-programmable clock divider; the top only turns the
// shared write port into per-channel load strobes.
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int                  NCH      = 4,
  parameter int                  CW       = CW_DEFAULT,
  parameter logic [NCH*CW-1:0]   DIV_INIT = {32'd50_000_000, 32'd5_000_000, 32'd500_000, 32'd50_000},
  localparam int                 CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_div,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0] load;

  // Out-of-range channel numbers match no channel, so such writes are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign load[i] = wr_en && (32'(wr_ch) == i);

    clk_div_channel #(
      .CW   (CW),
      .INIT (DIV_INIT[i*CW +: CW])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .sync     (sync),
      .load     (load[i]),
      .load_val (wr_div),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench: a closed-form per-channel model (edges elapsed since the
// last restart) is compared every cycle, with directed scenarios pinned by literals.
module tb_clock_divider_bank;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam logic [NCH*CW-1:0] TB_INIT = {32'd9, 32'd7, 32'd5, 32'd4};

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [CW-1:0]  wr_div;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  int unsigned init_div[NCH] = '{4, 5, 7, 9};
  int unsigned m_div[NCH];
  int unsigned m_since[NCH];
  bit          m_anchor[NCH];
  bit          m_out[NCH];
  bit          m_tick[NCH];

  clock_divider_bank #(
    .NCH      (NCH),
    .CW       (CW),
    .DIV_INIT (TB_INIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]    = init_div[i];
      m_since[i]  = 0;
      m_anchor[i] = 1'b0;
      m_out[i]    = 1'b0;
      m_tick[i]   = 1'b0;
    end
  endtask

  // Output level = level at last restart, flipped once per completed half-period.
  task automatic modelUpdate();
    int unsigned eff;
    bit hit;
    for (int i = 0; i < NCH; i++) begin
      eff = (m_div[i] == 0) ? 1 : m_div[i];
      hit = wr_en && (int'(wr_ch) == i);
      m_tick[i] = 1'b0;
      if (sync) begin
        m_since[i]  = 0;
        m_anchor[i] = 1'b0;
        m_out[i]    = 1'b0;
      end else if (hit) begin
        m_since[i]  = 0;
        m_anchor[i] = m_out[i];
      end else if (en[i]) begin
        m_since[i] = m_since[i] + 1;
        m_out[i]   = m_anchor[i] ^ (((m_since[i] / eff) % 2) == 1);
        m_tick[i]  = ((m_since[i] % eff) == 0) && m_out[i];
      end
      if (hit) m_div[i] = wr_div;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) modelUpdate();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] e, input bit s, input bit w,
                               input logic [1:0] ch, input logic [CW-1:0] d);
    en     = e;
    sync   = s;
    wr_en  = w;
    wr_ch  = ch;
    wr_div = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NCH; i++) begin
        total++;
        if (clk_out[i] !== m_out[i]) begin
          bad++;
          $display("[TB] FAIL model_clk_out[%0d] at %0t: got %b, expected %b", i, $time, clk_out[i], m_out[i]);
        end
        total++;
        if (tick[i] !== m_tick[i]) begin
          bad++;
          $display("[TB] FAIL model_tick[%0d] at %0t: got %b, expected %b", i, $time, tick[i], m_tick[i]);
        end
      end
    end
  end

  initial begin
    bit exp_o[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    bit exp_t[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};

    rst = 1'b1;
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    modelReset();
    repeat (3) cycle();
    checkOutput("reset_clk_out", 32'(clk_out), 0);
    checkOutput("reset_tick", 32'(tick), 0);
    rst = 1'b0;
    check_en = 1'b1;
    cycle();
    checkOutput("post_reset_clk_out", 32'(clk_out), 0);

    // ch0 div=3 with sync: period 6, tick at each rise
    applyStimulus(4'hF, 1, 1, 2'd0, 3);
    cycle();
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    for (int k = 0; k < 9; k++) begin
      cycle();
      checkOutput($sformatf("div3_out_e%0d", k + 1), 32'(clk_out[0]), 32'(exp_o[k]));
      checkOutput($sformatf("div3_tick_e%0d", k + 1), 32'(tick[0]), 32'(exp_t[k]));
    end

    // degenerate divide values on ch1
    for (int d = 0; d < 2; d++) begin
      applyStimulus(4'hF, 1, 1, 2'd1, CW'(d));
      cycle();
      applyStimulus(4'hF, 0, 0, 2'd0, 0);
      for (int k = 1; k <= 4; k++) begin
        cycle();
        checkOutput($sformatf("div%0d_out_e%0d", d, k), 32'(clk_out[1]), 32'(k % 2));
        checkOutput($sformatf("div%0d_tick_e%0d", d, k), 32'(tick[1]), 32'(k % 2));
      end
    end

    // ch2 div=5, rewritten to 2 at cnt=3
    applyStimulus(4'hF, 1, 1, 2'd2, 5);
    cycle();
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    repeat (3) cycle();
    applyStimulus(4'hF, 0, 1, 2'd2, 2);
    cycle();
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    checkOutput("midwrite_no_toggle", 32'(clk_out[2]), 0);
    cycle();
    checkOutput("midwrite_w1", 32'(clk_out[2]), 0);
    cycle();
    checkOutput("midwrite_w2_out", 32'(clk_out[2]), 1);
    checkOutput("midwrite_w2_tick", 32'(tick[2]), 1);
    cycle();
    cycle();
    checkOutput("midwrite_w4_fall", 32'(clk_out[2]), 0);

    // enable freeze on ch0 at div=4 during the high phase
    applyStimulus(4'hF, 1, 1, 2'd0, 4);
    cycle();
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    repeat (6) cycle();
    checkOutput("freeze_pre_high", 32'(clk_out[0]), 1);
    applyStimulus(4'b1110, 0, 0, 2'd0, 0);
    for (int k = 0; k < 7; k++) begin
      cycle();
      checkOutput($sformatf("freeze_hold_%0d", k), 32'(clk_out[0]), 1);
      checkOutput($sformatf("freeze_tick_%0d", k), 32'(tick[0]), 0);
    end
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    cycle();
    checkOutput("resume_still_high", 32'(clk_out[0]), 1);
    cycle();
    checkOutput("resume_fall", 32'(clk_out[0]), 0);
    repeat (4) cycle();
    checkOutput("resume_rise_out", 32'(clk_out[0]), 1);
    checkOutput("resume_rise_tick", 32'(tick[0]), 1);

    // sync + write ch3 while ch1 sits at terminal count
    applyStimulus(4'hF, 1, 1, 2'd1, 3);
    cycle();
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    repeat (2) cycle();
    applyStimulus(4'hF, 1, 1, 2'd3, 2);
    cycle();
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    checkOutput("collide_all_out", 32'(clk_out), 0);
    checkOutput("collide_all_tick", 32'(tick), 0);
    cycle();
    checkOutput("collide_ch3_e1", 32'(clk_out[3]), 0);
    cycle();
    checkOutput("collide_ch3_rise", 32'(clk_out[3]), 1);
    checkOutput("collide_ch3_tick", 32'(tick[3]), 1);
    checkOutput("collide_ch1_e2", 32'(clk_out[1]), 0);
    cycle();
    checkOutput("collide_ch1_rise", 32'(clk_out[1]), 1);

    // randomized traffic with small divide values
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 3) == 0) ? NCH'($urandom) : 4'hF,
                    ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 9) == 0),
                    2'($urandom_range(0, 3)),
                    CW'($urandom_range(0, 6)));
      cycle();
    end

    // async reset between edges; written divide values are lost
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    repeat (5) cycle();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out", 32'(clk_out), 0);
    checkOutput("async_rst_tick", 32'(tick), 0);
    modelReset();
    repeat (2) cycle();
    rst = 1'b0;
    applyStimulus(4'hF, 1, 0, 2'd0, 0);
    cycle();
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    repeat (4) cycle();
    checkOutput("init_ch0_rise", 32'(clk_out[0]), 1);
    checkOutput("init_ch0_tick", 32'(tick[0]), 1);
    checkOutput("init_ch1_low", 32'(clk_out[1]), 0);
    cycle();
    checkOutput("init_ch1_rise", 32'(clk_out[1]), 1);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
